mem_arbiter: RTL and testbench

- Owns the single byte-wide RAM/IO bus and shares it between the instruction Fetcher (4-byte reads) and the LoadStoreBuffer (1/2/4-byte reads and writes).
- Serialises each multi-byte request into byte transactions, assembles or disassembles little-endian words, and returns a one-cycle ready pulse to the requester.
- Honours rdy_in pause, io_buffer_full back-pressure, and fetch abort on pipeline flush.
- Sits between cpu top-level memory pins and Fetcher/LoadStoreBuffer; supersedes direct Fetcher wiring.

---
 rtl/mem_arbiter_pkg.sv | 34 +++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_byte_sequencer.sv | 86 ++++++++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide memory arbiter: FSM states, owners, goal sizes.
// Helper maps an LSB goal code onto the number of byte transactions to run.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    localparam logic [2:0] GOAL_BYTE = 3'd1;
    localparam logic [2:0] GOAL_HALF = 3'd2;
    localparam logic [2:0] GOAL_WORD = 3'd4;

    localparam logic [1:0] IO_REGION_DEFAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_FET = 1'b0,
        OWN_LSB = 1'b1
    } owner_e;

    function automatic logic [2:0] goal_len(input logic [2:0] goal);
        case (goal)
            GOAL_BYTE: return GOAL_BYTE;
            GOAL_HALF: return GOAL_HALF;
            default:   return GOAL_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory pins plus Fetcher and LoadStoreBuffer handshakes as seen by the arbiter.
// master = arbiter side, slave = CPU pins / requesters side.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic                rdy_in;
    logic                io_buffer_full;
    logic [BYTE_W-1:0]   ram_data_in;
    logic [BYTE_W-1:0]   ram_data_out;
    logic [WORD_W-1:0]   ram_address_out;
    logic                ram_rw_signal_out;

    logic                fet_request_signal_in;
    logic [WORD_W-1:0]   fet_address_in;
    logic                fet_abort_in;
    logic                fet_ready_out;
    logic [WORD_W-1:0]   fet_instruction_out;

    logic                lsb_request_signal_in;
    logic                lsb_rw_signal_in;
    logic [WORD_W-1:0]   lsb_address_in;
    logic [2:0]          lsb_goal_in;
    logic [WORD_W-1:0]   lsb_data_in;
    logic                lsb_ready_out;
    logic [WORD_W-1:0]   lsb_data_out;

    modport master (
        input  rdy_in, io_buffer_full, ram_data_in,
        output ram_data_out, ram_address_out, ram_rw_signal_out,
        input  fet_request_signal_in, fet_address_in, fet_abort_in,
        output fet_ready_out, fet_instruction_out,
        input  lsb_request_signal_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        output lsb_ready_out, lsb_data_out
    );

    modport slave (
        output rdy_in, io_buffer_full, ram_data_in,
        input  ram_data_out, ram_address_out, ram_rw_signal_out,
        output fet_request_signal_in, fet_address_in, fet_abort_in,
        input  fet_ready_out, fet_instruction_out,
        output lsb_request_signal_in, lsb_rw_signal_in, lsb_address_in, lsb_goal_in, lsb_data_in,
        input  lsb_ready_out, lsb_data_out
    );

endinterface

// File: rtl/mem_byte_sequencer.sv
// Byte sequencer: walks A..A+N-1, packs read bytes little-endian, picks write bytes.
// Address of byte k is combinational on start, then one byte per cycle; run=0 freezes everything.
module mem_byte_sequencer
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              start,
    input  logic [WORD_W-1:0] start_addr,
    input  logic [2:0]        start_len,
    input  logic              rd_active,
    input  logic              wr_active,
    input  logic              wr_sel,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BYTE_W-1:0] ram_data_in,
    output logic [WORD_W-1:0] ram_address,
    output logic [BYTE_W-1:0] wbyte,
    output logic [2:0]        cnt,
    output logic [2:0]        len,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] base_q, base_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [2:0]        cnt_q,  cnt_d;
    logic [2:0]        len_q,  len_d;

    logic [1:0]        idx;
    logic [1:0]        cap_idx;
    logic [WORD_W-1:0] issue_base;
    logic              issue;

    always_comb begin
        idx        = start ? 2'd0 : cnt_q[1:0];
        cap_idx    = 2'(cnt_q - 3'd1);
        issue_base = start ? start_addr : base_q;
        // A read has issued its last address once cnt reaches len; only the final capture remains.
        issue      = start || wr_active || (rd_active && (cnt_q < len_q));

        ram_address = (run && issue) ? issue_base + {30'd0, idx} : addr_q;
        wbyte       = wr_sel ? wdata[8*idx +: 8] : 8'h00;

        base_d = base_q;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        len_d  = len_q;
        if (run) begin
            addr_d = ram_address;
            if (start) begin
                base_d = start_addr;
                len_d  = start_len;
                cnt_d  = 3'd1;
                data_d = '0;
            end else if (rd_active || wr_active) begin
                cnt_d = cnt_q + 3'd1;
                if (rd_active) begin
                    data_d[8*cap_idx +: 8] = ram_data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            len_q  <= '0;
        end else begin
            base_q <= base_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            len_q  <= len_d;
        end
    end

    assign cnt   = cnt_q;
    assign len   = len_q;
    assign rdata = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM/IO bus between Fetcher and LSB; one ready pulse per request.
// Latency: read N+1 cycles, write N cycles from grant; rdy_in low freezes, IO stores wait out io_buffer_full.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit         LSB_PRIORITY = 1'b1,
    parameter logic [1:0] IO_REGION    = IO_REGION_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    state_e state_q, state_d;
    owner_e owner_q, owner_d;
    logic   ptr_q, ptr_d;
    logic   live_q, live_d;

    logic              io_blk, fet_ok, lsb_ok, pick_lsb, idle_go;
    logic              grant_fet, grant_lsb, start, start_wr;
    logic [WORD_W-1:0] start_addr;
    logic [2:0]        start_len;
    logic [2:0]        cnt, len;
    logic [WORD_W-1:0] rdata;
    logic [WORD_W-1:0] seq_addr;
    logic [BYTE_W-1:0] seq_wbyte;

    // live_q keeps the bus quiet while reset is held and for the first cycle after release.
    always_comb begin
        io_blk   = bus.lsb_rw_signal_in && (bus.lsb_address_in[17:16] == IO_REGION) && bus.io_buffer_full;
        fet_ok   = bus.fet_request_signal_in && !bus.fet_abort_in;
        lsb_ok   = bus.lsb_request_signal_in && !io_blk;
        pick_lsb = lsb_ok && (!fet_ok || LSB_PRIORITY || ptr_q);
        idle_go  = live_q && bus.rdy_in && (state_q == ST_IDLE);

        grant_lsb  = idle_go && pick_lsb;
        grant_fet  = idle_go && fet_ok && !pick_lsb;
        start      = grant_lsb || grant_fet;
        start_wr   = grant_lsb && bus.lsb_rw_signal_in;
        start_addr = grant_lsb ? bus.lsb_address_in : bus.fet_address_in;
        start_len  = grant_lsb ? goal_len(bus.lsb_goal_in) : GOAL_WORD;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        live_d  = 1'b1;
        if (bus.rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        owner_d = grant_lsb ? OWN_LSB : OWN_FET;
                        ptr_d   = LSB_PRIORITY ? ptr_q : ~ptr_q;
                        if (!start_wr)                  state_d = ST_READ;
                        else if (start_len == GOAL_BYTE) state_d = ST_DONE;
                        else                            state_d = ST_WRITE;
                    end
                end
                ST_READ: begin
                    if (owner_q == OWN_FET && bus.fet_abort_in) state_d = ST_IDLE;
                    else if (cnt == len)                        state_d = ST_DONE;
                end
                ST_WRITE: begin
                    if (cnt == len - 3'd1) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_FET;
            ptr_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            live_q  <= live_d;
        end
    end

    mem_byte_sequencer u_seq (
        .clk         (clk),
        .rst         (rst),
        .run         (bus.rdy_in),
        .start       (start),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .rd_active   (state_q == ST_READ),
        .wr_active   (state_q == ST_WRITE),
        .wr_sel      (start_wr || (state_q == ST_WRITE)),
        .wdata       (bus.lsb_data_in),
        .ram_data_in (bus.ram_data_in),
        .ram_address (seq_addr),
        .wbyte       (seq_wbyte),
        .cnt         (cnt),
        .len         (len),
        .rdata       (rdata)
    );

    // Ready is gated by rdy_in so a pulse falling in a pause is shown on the first active cycle.
    assign bus.ram_address_out     = seq_addr;
    assign bus.ram_data_out        = seq_wbyte;
    assign bus.ram_rw_signal_out   = bus.rdy_in && (start_wr || (state_q == ST_WRITE));
    assign bus.fet_ready_out       = bus.rdy_in && (state_q == ST_DONE) && (owner_q == OWN_FET) && !bus.fet_abort_in;
    assign bus.lsb_ready_out       = bus.rdy_in && (state_q == ST_DONE) && (owner_q == OWN_LSB);
    assign bus.fet_instruction_out = rdata;
    assign bus.lsb_data_out        = rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model; expected values computed by hand.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   wr_count = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.LSB_PRIORITY(1'b1), .IO_REGION(2'b11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 8'h13;
            32'h0000_0101: return 8'h05;
            32'h0000_0300: return 8'h80;
            32'hFFFF_FFFE: return 8'h11;
            32'hFFFF_FFFF: return 8'h22;
            32'h0000_0000: return 8'h33;
            32'h0000_0001: return 8'h44;
            default:       return 8'h00;
        endcase
    endfunction

    // RAM: read data valid the cycle after its address; count write strobes.
    always @(posedge clk) begin
        bus.ram_data_in <= byte_at(bus.ram_address_out);
        if (bus.ram_rw_signal_out) wr_count <= wr_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.ram_data_in = 8'h00;
        bus.rdy_in = 1'b1;
        bus.io_buffer_full = 1'b0;
        bus.fet_request_signal_in = 1'b0;
        bus.fet_address_in = '0;
        bus.fet_abort_in = 1'b0;
        bus.lsb_request_signal_in = 1'b0;
        bus.lsb_rw_signal_in = 1'b0;
        bus.lsb_address_in = '0;
        bus.lsb_goal_in = 3'd0;
        bus.lsb_data_in = '0;

        #3;
        chk("rst_addr", bus.ram_address_out, 32'h0);
        chk("rst_rw", bus.ram_rw_signal_out, 0);
        chk("rst_wdat", bus.ram_data_out, 0);
        chk("rst_fet_rdy", bus.fet_ready_out, 0);
        chk("rst_lsb_rdy", bus.lsb_ready_out, 0);
        chk("rst_instr", bus.fet_instruction_out, 0);
        chk("rst_ldata", bus.lsb_data_out, 0);
        repeat (2) step();
        rst = 1'b1;
        step();
        step();

        // Plain fetch at 0x100
        bus.fet_request_signal_in = 1'b1;
        bus.fet_address_in = 32'h100;
        #1;
        chk("f_a0", bus.ram_address_out, 32'h100);
        chk("f_rw0", bus.ram_rw_signal_out, 0);
        for (int k = 1; k < 4; k++) begin
            step(); #1;
            chk("f_ak", bus.ram_address_out, 32'h100 + k);
            chk("f_rwk", bus.ram_rw_signal_out, 0);
        end
        step(); #1;
        chk("f_rdy4", bus.fet_ready_out, 0);
        step(); #1;
        chk("f_rdy5", bus.fet_ready_out, 1);
        chk("f_instr", bus.fet_instruction_out, 32'h0000_0513);
        step();
        bus.fet_request_signal_in = 1'b0;
        #1;
        chk("f_rdy6", bus.fet_ready_out, 0);

        // Halfword store at 0x200
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_rw_signal_in = 1'b1;
        bus.lsb_address_in = 32'h200;
        bus.lsb_goal_in = 3'd2;
        bus.lsb_data_in = 32'hAABB_CCDD;
        #1;
        chk("s_a0", bus.ram_address_out, 32'h200);
        chk("s_d0", bus.ram_data_out, 32'hDD);
        chk("s_rw0", bus.ram_rw_signal_out, 1);
        step(); #1;
        chk("s_a1", bus.ram_address_out, 32'h201);
        chk("s_d1", bus.ram_data_out, 32'hCC);
        chk("s_rw1", bus.ram_rw_signal_out, 1);
        chk("s_rdy1", bus.lsb_ready_out, 0);
        step(); #1;
        chk("s_rdy2", bus.lsb_ready_out, 1);
        chk("s_rw2", bus.ram_rw_signal_out, 0);
        chk("s_a2", bus.ram_address_out, 32'h201);
        step();
        bus.lsb_request_signal_in = 1'b0;
        bus.lsb_rw_signal_in = 1'b0;
        #1;
        chk("s_rw3", bus.ram_rw_signal_out, 0);
        chk("s_wrcnt", wr_count, 2);

        // Both pending: LSB byte load wins, fetch follows
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_address_in = 32'h300;
        bus.lsb_goal_in = 3'd1;
        bus.fet_request_signal_in = 1'b1;
        bus.fet_address_in = 32'h100;
        #1;
        chk("b_a0", bus.ram_address_out, 32'h300);
        chk("b_rw0", bus.ram_rw_signal_out, 0);
        step(); #1;
        chk("b_lrdy1", bus.lsb_ready_out, 0);
        step(); #1;
        chk("b_lrdy2", bus.lsb_ready_out, 1);
        chk("b_ldata", bus.lsb_data_out, 32'h0000_0080);
        chk("b_frdy2", bus.fet_ready_out, 0);
        step();
        bus.lsb_request_signal_in = 1'b0;
        #1;
        chk("b_fgrant", bus.ram_address_out, 32'h100);
        repeat (4) step();
        #1;
        chk("b_frdy7", bus.fet_ready_out, 0);
        step(); #1;
        chk("b_frdy8", bus.fet_ready_out, 1);
        chk("b_instr", bus.fet_instruction_out, 32'h0000_0513);
        step();
        bus.fet_request_signal_in = 1'b0;

        // Goal code 3 means word; address wraps past 0xFFFFFFFF
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_address_in = 32'hFFFF_FFFE;
        bus.lsb_goal_in = 3'd3;
        #1;
        chk("w_a0", bus.ram_address_out, 32'hFFFF_FFFE);
        step(); #1;
        chk("w_a1", bus.ram_address_out, 32'hFFFF_FFFF);
        step(); #1;
        chk("w_a2", bus.ram_address_out, 32'h0000_0000);
        step(); #1;
        chk("w_a3", bus.ram_address_out, 32'h0000_0001);
        step(); #1;
        chk("w_rdy4", bus.lsb_ready_out, 0);
        step(); #1;
        chk("w_rdy5", bus.lsb_ready_out, 1);
        chk("w_data", bus.lsb_data_out, 32'h4433_2211);
        step();
        bus.lsb_request_signal_in = 1'b0;

        // IO store held off by io_buffer_full for 10 cycles
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_rw_signal_in = 1'b1;
        bus.lsb_address_in = 32'h0003_0000;
        bus.lsb_goal_in = 3'd1;
        bus.lsb_data_in = 32'h0000_0041;
        bus.io_buffer_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("io_rw_full", bus.ram_rw_signal_out, 0);
            step();
        end
        bus.io_buffer_full = 1'b0;
        #1;
        chk("io_rw", bus.ram_rw_signal_out, 1);
        chk("io_addr", bus.ram_address_out, 32'h0003_0000);
        chk("io_dat", bus.ram_data_out, 32'h41);
        chk("io_rdy0", bus.lsb_ready_out, 0);
        step(); #1;
        chk("io_rdy1", bus.lsb_ready_out, 1);
        chk("io_rw1", bus.ram_rw_signal_out, 0);
        step();
        bus.lsb_request_signal_in = 1'b0;
        bus.lsb_rw_signal_in = 1'b0;
        #1;
        chk("io_wrcnt", wr_count, 3);

        // Fetch with rdy_in low for 3 cycles after byte 1 is issued
        bus.fet_request_signal_in = 1'b1;
        bus.fet_address_in = 32'h100;
        #1;
        chk("p_a0", bus.ram_address_out, 32'h100);
        step(); #1;
        chk("p_a1", bus.ram_address_out, 32'h101);
        step();
        bus.rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("p_hold_a", bus.ram_address_out, 32'h101);
            chk("p_hold_rw", bus.ram_rw_signal_out, 0);
            chk("p_hold_rdy", bus.fet_ready_out, 0);
            step();
        end
        bus.rdy_in = 1'b1;
        #1;
        chk("p_a2", bus.ram_address_out, 32'h102);
        step(); #1;
        chk("p_a3", bus.ram_address_out, 32'h103);
        step(); #1;
        chk("p_rdy7", bus.fet_ready_out, 0);
        step(); #1;
        chk("p_rdy8", bus.fet_ready_out, 1);
        chk("p_instr", bus.fet_instruction_out, 32'h0000_0513);
        step();
        bus.fet_request_signal_in = 1'b0;

        // Fetch aborted in cycle 2; pending LSB load taken straight after
        bus.fet_request_signal_in = 1'b1;
        bus.fet_address_in = 32'h100;
        #1;
        chk("a_a0", bus.ram_address_out, 32'h100);
        step();
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_rw_signal_in = 1'b0;
        bus.lsb_address_in = 32'h300;
        bus.lsb_goal_in = 3'd1;
        #1;
        chk("a_a1", bus.ram_address_out, 32'h101);
        step();
        bus.fet_abort_in = 1'b1;
        #1;
        chk("a_frdy2", bus.fet_ready_out, 0);
        step();
        bus.fet_request_signal_in = 1'b0;
        bus.fet_abort_in = 1'b0;
        #1;
        chk("a_lgrant", bus.ram_address_out, 32'h300);
        chk("a_frdy3", bus.fet_ready_out, 0);
        step(); #1;
        chk("a_frdy4", bus.fet_ready_out, 0);
        step(); #1;
        chk("a_lrdy5", bus.lsb_ready_out, 1);
        chk("a_ldata", bus.lsb_data_out, 32'h0000_0080);
        chk("a_frdy5", bus.fet_ready_out, 0);
        step();
        bus.lsb_request_signal_in = 1'b0;

        // Reset in the middle of a word store
        bus.lsb_request_signal_in = 1'b1;
        bus.lsb_rw_signal_in = 1'b1;
        bus.lsb_address_in = 32'h200;
        bus.lsb_goal_in = 3'd4;
        bus.lsb_data_in = 32'h1122_3344;
        #1;
        chk("r_rw0", bus.ram_rw_signal_out, 1);
        chk("r_d0", bus.ram_data_out, 32'h44);
        step();
        rst = 1'b0;
        #1;
        chk("r_rw", bus.ram_rw_signal_out, 0);
        chk("r_addr", bus.ram_address_out, 32'h0);
        chk("r_rdy", bus.lsb_ready_out, 0);
        bus.lsb_request_signal_in = 1'b0;
        bus.lsb_rw_signal_in = 1'b0;
        step();
        rst = 1'b1;
        step(); step(); #1;
        chk("r_after_rw", bus.ram_rw_signal_out, 0);
        chk("r_after_rdy", bus.lsb_ready_out, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
